pulse_gen_multi: RTL and testbench

PULSE_GEN_MULTI -- requirements
Module: pulse_gen_multi

---
 rtl/pulse_gen_multi.sv | 127 ++++++++++++
 tb/tb_pulse_gen_multi.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_gen_multi.sv
// Multi-channel pulse generator: NCH independent one-shot/periodic channels.
// Optional restart-while-busy behaviour enabled by PULSE_GEN_RETRIGGER_EN.
module pulse_gen_multi #(
  parameter int NCH   = 4,
  parameter int CNT_W = 8
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [NCH-1:0]       start,
  input  logic [NCH-1:0]       stop,
  input  logic [NCH-1:0]       mode,
  input  logic [NCH*CNT_W-1:0] width,
  input  logic [NCH*CNT_W-1:0] period,
  output logic [NCH-1:0]       pulse,
  output logic [NCH-1:0]       busy,
  output logic [NCH-1:0]       done
);

  typedef enum logic [1:0] {
    IDLE,
    HIGH,
    LOW
  } state_t;

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] w_q;
    logic [CNT_W-1:0] p_q;
    logic             m_q;
    logic             pulse_q;
    logic             busy_q;
    logic             done_q;
    logic [CNT_W-1:0] w_in;
    logic [CNT_W-1:0] p_in;
    logic [CNT_W-1:0] low_len;
    logic             go;
    logic             trig;

    assign w_in = width[i*CNT_W +: CNT_W];
    assign p_in = period[i*CNT_W +: CNT_W];
    assign go   = start[i] & ~stop[i] & (w_in != '0);

`ifdef PULSE_GEN_RETRIGGER_EN
    assign trig = go;
`else
    assign trig = go & (state == IDLE);
`endif

    // Gap after the high phase; at least one cycle so the pulse toggles.
    assign low_len = (p_q > w_q) ? (p_q - w_q) : ONE;

    // Channel FSM with registered pulse/busy/done.
    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        state   <= IDLE;
        cnt     <= '0;
        w_q     <= '0;
        p_q     <= '0;
        m_q     <= 1'b0;
        pulse_q <= 1'b0;
        busy_q  <= 1'b0;
        done_q  <= 1'b0;
      end else begin
        done_q <= 1'b0;
        if (stop[i]) begin
          state   <= IDLE;
          cnt     <= '0;
          pulse_q <= 1'b0;
          busy_q  <= 1'b0;
        end else if (trig) begin
          w_q     <= w_in;
          p_q     <= p_in;
          m_q     <= mode[i];
          cnt     <= w_in;
          state   <= HIGH;
          pulse_q <= 1'b1;
          busy_q  <= 1'b1;
        end else begin
          unique case (state)
            IDLE: begin
              cnt <= '0;
            end
            HIGH: begin
              if (cnt == ONE) begin
                pulse_q <= 1'b0;
                if (m_q) begin
                  state <= LOW;
                  cnt   <= low_len;
                end else begin
                  state  <= IDLE;
                  cnt    <= '0;
                  busy_q <= 1'b0;
                  done_q <= 1'b1;
                end
              end else begin
                cnt <= cnt - ONE;
              end
            end
            LOW: begin
              if (cnt == ONE) begin
                state   <= HIGH;
                cnt     <= w_q;
                pulse_q <= 1'b1;
              end else begin
                cnt <= cnt - ONE;
              end
            end
            default: begin
              state   <= IDLE;
              cnt     <= '0;
              pulse_q <= 1'b0;
              busy_q  <= 1'b0;
            end
          endcase
        end
      end
    end

    assign pulse[i] = pulse_q;
    assign busy[i]  = busy_q;
    assign done[i]  = done_q;
  end

endmodule

// File: tb/tb_pulse_gen_multi.sv
// Randomized + directed bench for pulse_gen_multi.
// Reference model tracks elapsed cycles since start per channel.
module tb_pulse_gen_multi;

  localparam int NCH   = 4;
  localparam int CNT_W = 8;

`ifdef PULSE_GEN_RETRIGGER_EN
  localparam bit RETRIG = 1'b1;
`else
  localparam bit RETRIG = 1'b0;
`endif

  logic                 clock;
  logic                 reset_n;
  logic [NCH-1:0]       start;
  logic [NCH-1:0]       stop;
  logic [NCH-1:0]       mode;
  logic [NCH*CNT_W-1:0] width;
  logic [NCH*CNT_W-1:0] period;
  logic [NCH-1:0]       pulse;
  logic [NCH-1:0]       busy;
  logic [NCH-1:0]       done;

  pulse_gen_multi #(.NCH(NCH), .CNT_W(CNT_W)) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .start  (start),
    .stop   (stop),
    .mode   (mode),
    .width  (width),
    .period (period),
    .pulse  (pulse),
    .busy   (busy),
    .done   (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;

  // model: run flag, cycles elapsed since start, latched params
  bit run [NCH];
  bit dn  [NCH];
  int k   [NCH];
  int mw  [NCH];
  int mp  [NCH];
  bit mm  [NCH];
  int hi_cnt [NCH];
  int dn_cnt [NCH];

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int per_len(input int w, input int p);
    return w + ((p > w) ? (p - w) : 1);
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      run[c] = 0; dn[c] = 0; k[c] = 0;
      mw[c] = 0; mp[c] = 0; mm[c] = 0;
    end
  endtask

  task automatic model_edge();
    for (int c = 0; c < NCH; c++) begin
      int w;
      bit d;
      w = int'(width[c*CNT_W +: CNT_W]);
      d = 0;
      if (stop[c]) begin
        run[c] = 0;
      end else if (start[c] && w != 0 && (!run[c] || RETRIG)) begin
        run[c] = 1; k[c] = 0;
        mw[c] = w;
        mp[c] = int'(period[c*CNT_W +: CNT_W]);
        mm[c] = mode[c];
      end else if (run[c]) begin
        k[c]++;
        if (!mm[c]) begin
          if (k[c] == mw[c]) begin
            run[c] = 0; d = 1;
          end
        end else begin
          k[c] = k[c] % per_len(mw[c], mp[c]);
        end
      end
      dn[c] = d;
    end
  endtask

  task automatic compare(input string tag);
    logic [NCH-1:0] ep, eb, ed;
    for (int c = 0; c < NCH; c++) begin
      ep[c] = run[c] && (k[c] < mw[c]);
      eb[c] = run[c];
      ed[c] = dn[c];
    end
    chk({tag, ".pulse"}, 32'(pulse), 32'(ep));
    chk({tag, ".busy"},  32'(busy),  32'(eb));
    chk({tag, ".done"},  32'(done),  32'(ed));
  endtask

  task automatic step(input string tag);
    @(posedge clock);
    model_edge();
    #1;
    compare(tag);
    for (int c = 0; c < NCH; c++) begin
      if (pulse[c] === 1'b1) hi_cnt[c]++;
      if (done[c] === 1'b1) dn_cnt[c]++;
    end
  endtask

  task automatic clr_cnt();
    for (int c = 0; c < NCH; c++) begin
      hi_cnt[c] = 0; dn_cnt[c] = 0;
    end
  endtask

  task automatic cfg(input int c, input bit md, input int w, input int p);
    mode[c] = md;
    width[c*CNT_W +: CNT_W]  = CNT_W'(w);
    period[c*CNT_W +: CNT_W] = CNT_W'(p);
  endtask

  task automatic idle_in();
    start = '0;
    stop  = '0;
  endtask

  initial begin
    reset_n = 1'b0;
    idle_in();
    mode = '0; width = '0; period = '0;
    model_reset();
    clr_cnt();
    #12;
    compare("reset");
    reset_n = 1'b1;

    // one-shot, started right after reset release
    cfg(0, 0, 8, 0);
    start[0] = 1'b1;
    step("os");
    idle_in();
    for (int n = 0; n < 12; n++) step("os");
    chk("os_high", hi_cnt[0], 8);
    chk("os_done", dn_cnt[0], 1);

    // periodic 3/10
    clr_cnt();
    cfg(1, 1, 3, 10);
    start[1] = 1'b1;
    step("per");
    idle_in();
    cfg(1, 0, 7, 2);
    for (int n = 0; n < 54; n++) step("per");
    chk("per_high", hi_cnt[1], 18);
    chk("per_done", dn_cnt[1], 0);
    stop[1] = 1'b1;
    step("per_stop");
    idle_in();

    // width zero ignored
    clr_cnt();
    cfg(2, 0, 0, 0);
    start[2] = 1'b1;
    step("w0");
    idle_in();
    step("w0");
    chk("w0_busy", hi_cnt[2] + dn_cnt[2] + 32'(busy[2]), 0);

    // periodic with P<=W
    clr_cnt();
    cfg(2, 1, 5, 4);
    start[2] = 1'b1;
    step("p_le_w");
    idle_in();
    for (int n = 0; n < 11; n++) step("p_le_w");
    chk("p_le_w_high", hi_cnt[2], 10);
    stop[2] = 1'b1;
    step("p_le_w");
    idle_in();

    // full-scale width
    clr_cnt();
    cfg(3, 0, 255, 0);
    start[3] = 1'b1;
    step("w255");
    idle_in();
    for (int n = 0; n < 260; n++) step("w255");
    chk("w255_high", hi_cnt[3], 255);
    chk("w255_done", dn_cnt[3], 1);

    // stop at high cycle 4
    clr_cnt();
    cfg(0, 0, 8, 0);
    start[0] = 1'b1;
    step("stop");
    idle_in();
    for (int n = 0; n < 3; n++) step("stop");
    stop[0] = 1'b1;
    step("stop");
    idle_in();
    for (int n = 0; n < 6; n++) step("stop");
    chk("stop_high", hi_cnt[0], 4);
    chk("stop_done", dn_cnt[0], 0);

    // start and stop collide
    clr_cnt();
    start[0] = 1'b1;
    stop[0]  = 1'b1;
    step("coll");
    idle_in();
    step("coll");
    chk("coll_high", hi_cnt[0], 0);

    // async reset mid-high
    clr_cnt();
    start[0] = 1'b1;
    step("arst");
    idle_in();
    step("arst");
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    compare("arst_now");
    @(posedge clock);
    #1;
    compare("arst_hold");
    @(negedge clock);
    reset_n = 1'b1;
    clr_cnt();
    cfg(0, 0, 8, 0);
    start[0] = 1'b1;
    step("arst_os");
    idle_in();
    for (int n = 0; n < 12; n++) step("arst_os");
    chk("arst_os_high", hi_cnt[0], 8);
    chk("arst_os_done", dn_cnt[0], 1);

    // restart while busy
    clr_cnt();
    cfg(0, 0, 8, 0);
    start[0] = 1'b1;
    step("retrig");
    idle_in();
    for (int n = 0; n < 4; n++) step("retrig");
    start[0] = 1'b1;
    step("retrig");
    idle_in();
    for (int n = 0; n < 16; n++) step("retrig");
    chk("retrig_high", hi_cnt[0], RETRIG ? 13 : 8);

    // random traffic on all channels
    for (int n = 0; n < 3000; n++) begin
      for (int c = 0; c < NCH; c++) begin
        start[c] = ($urandom_range(0, 7) == 0);
        stop[c]  = ($urandom_range(0, 39) == 0);
        mode[c]  = $urandom_range(0, 1);
        if ($urandom_range(0, 49) == 0)
          width[c*CNT_W +: CNT_W] = 8'd255;
        else
          width[c*CNT_W +: CNT_W] = CNT_W'($urandom_range(0, 12));
        period[c*CNT_W +: CNT_W] = CNT_W'($urandom_range(0, 16));
      end
      step("rand");
    end
    idle_in();
    step("rand_end");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
